// File: rtl/ntt_tile_scheduler.sv
// ntt_tile_scheduler: sequences the two matrix-multiply passes of a 2D NTT (N = N1*N2)
// over a tiled systolic engine. It issues one tile command at a time over a valid/ready
// handshake, waits for that tile's completion pulse, and pulses done after the last
// pass-two tile.
//
// Ports:
//   clk, srstn            clock and synchronous active-low reset
//   start                 begin a two-pass job (sampled in IDLE only)
//   busy, done            job in progress / one-cycle completion pulse
//   tile_valid/ready      command handshake toward the tile engine
//   tile_pass/row/col/k   command fields; tile_last marks the final tile of a pass
//   tile_done             engine pulse: the issued tile finished and was written back
//   err                   sticky protocol-violation flag (tile_done outside WAIT)
//   cycle_cnt             busy-cycle counter, present only when NTT_SCHED_PERF_EN is defined
//
// Optional feature macro: NTT_SCHED_PERF_EN

module ntt_tile_scheduler #(
    parameter int unsigned N1            = 16,
    parameter int unsigned N2            = 16,
    parameter int unsigned ARRAY_ROWS    = 4,
    parameter int unsigned ARRAY_COLUMNS = 4,
    parameter int unsigned IDX_W         = 16
) (
    input  logic             clk,
    input  logic             srstn,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             tile_valid,
    input  logic             tile_ready,
    output logic             tile_pass,
    output logic [IDX_W-1:0] tile_row,
    output logic [IDX_W-1:0] tile_col,
    output logic [11:0]      tile_k,
    output logic             tile_last,
    input  logic             tile_done,
`ifdef NTT_SCHED_PERF_EN
    output logic [31:0]      cycle_cnt,
`endif
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             valid_q, valid_d;
    logic             pass_q, pass_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic [11:0]      k_q, k_d;
    logic             err_q, err_d;
`ifdef NTT_SCHED_PERF_EN
    logic [31:0]      cnt_q, cnt_d;
`endif

    logic [IDX_W-1:0] last_row, last_col;
    logic             at_last;

    // Pass one walks an (N1/R) x (N2/C) grid, pass two the transposed (N2/R) x (N1/C) grid.
    assign last_row = pass_q ? IDX_W'(N2 / ARRAY_ROWS - 1)    : IDX_W'(N1 / ARRAY_ROWS - 1);
    assign last_col = pass_q ? IDX_W'(N1 / ARRAY_COLUMNS - 1) : IDX_W'(N2 / ARRAY_COLUMNS - 1);
    assign at_last  = (row_q == last_row) && (col_q == last_col);

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        pass_d  = pass_q;
        row_d   = row_q;
        col_d   = col_q;
        k_d     = k_q;
        err_d   = err_q;
`ifdef NTT_SCHED_PERF_EN
        cnt_d   = busy_q ? cnt_q + 32'd1 : cnt_q;
`endif

        // A completion pulse is only legal while a tile is outstanding; otherwise it is
        // flagged and otherwise ignored (this includes the accept cycle itself).
        if (tile_done && (state_q != StWait)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StIssue;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    pass_d  = 1'b0;
                    row_d   = '0;
                    col_d   = '0;
                    k_d     = 12'(N1);
`ifdef NTT_SCHED_PERF_EN
                    cnt_d   = '0;
`endif
                end
            end
            StIssue: begin
                if (tile_ready) begin
                    state_d = StWait;
                    valid_d = 1'b0;
                end
            end
            StWait: begin
                if (tile_done) begin
                    if (!at_last) begin
                        if (col_q == last_col) begin
                            col_d = '0;
                            row_d = row_q + IDX_W'(1);
                        end else begin
                            col_d = col_q + IDX_W'(1);
                        end
                        state_d = StIssue;
                        valid_d = 1'b1;
                    end else if (!pass_q) begin
                        // Switch straight into pass two without an idle cycle.
                        pass_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                        k_d     = 12'(N2);
                        state_d = StIssue;
                        valid_d = 1'b1;
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            pass_q  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            err_q   <= 1'b0;
`ifdef NTT_SCHED_PERF_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            pass_q  <= pass_d;
            row_q   <= row_d;
            col_q   <= col_d;
            k_q     <= k_d;
            err_q   <= err_d;
`ifdef NTT_SCHED_PERF_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign tile_valid = valid_q;
    assign tile_pass  = pass_q;
    assign tile_row   = row_q;
    assign tile_col   = col_q;
    assign tile_k     = k_q;
    assign tile_last  = at_last;
    assign err        = err_q;
`ifdef NTT_SCHED_PERF_EN
    assign cycle_cnt  = cnt_q;
`endif

endmodule

// File: tb/tb_ntt_tile_scheduler.sv
// Directed bench for ntt_tile_scheduler: a 16x16 instance (a_*) and an 8x16 instance (b_*),
// selected by sel; a cycle-stepped engine model answers each accepted tile after lat cycles.

module tb_ntt_tile_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srstn, start, tile_ready, tile_done_in, sel;
    int total = 0;
    int bad   = 0;

    logic        a_busy, a_done, a_valid, a_pass, a_last, a_err;
    logic [15:0] a_row, a_col;
    logic [11:0] a_k;
    logic        b_busy, b_done, b_valid, b_pass, b_last, b_err;
    logic [15:0] b_row, b_col;
    logic [11:0] b_k;
    logic [31:0] a_cnt, b_cnt;

    ntt_tile_scheduler u_dut_a (
        .clk       (clk),
        .srstn     (srstn),
        .start     (start & ~sel),
        .busy      (a_busy),
        .done      (a_done),
        .tile_valid(a_valid),
        .tile_ready(tile_ready & ~sel),
        .tile_pass (a_pass),
        .tile_row  (a_row),
        .tile_col  (a_col),
        .tile_k    (a_k),
        .tile_last (a_last),
        .tile_done (tile_done_in & ~sel),
`ifdef NTT_SCHED_PERF_EN
        .cycle_cnt (a_cnt),
`endif
        .err       (a_err)
    );

    ntt_tile_scheduler #(.N1(8), .N2(16)) u_dut_b (
        .clk       (clk),
        .srstn     (srstn),
        .start     (start & sel),
        .busy      (b_busy),
        .done      (b_done),
        .tile_valid(b_valid),
        .tile_ready(tile_ready & sel),
        .tile_pass (b_pass),
        .tile_row  (b_row),
        .tile_col  (b_col),
        .tile_k    (b_k),
        .tile_last (b_last),
        .tile_done (tile_done_in & sel),
`ifdef NTT_SCHED_PERF_EN
        .cycle_cnt (b_cnt),
`endif
        .err       (b_err)
    );

`ifndef NTT_SCHED_PERF_EN
    assign a_cnt = '0;
    assign b_cnt = '0;
`endif

    logic        m_busy, m_done, m_valid, m_pass, m_last, m_err;
    logic [15:0] m_row, m_col;
    logic [11:0] m_k;
    logic [31:0] m_cnt;
    assign m_busy  = sel ? b_busy  : a_busy;
    assign m_done  = sel ? b_done  : a_done;
    assign m_valid = sel ? b_valid : a_valid;
    assign m_pass  = sel ? b_pass  : a_pass;
    assign m_last  = sel ? b_last  : a_last;
    assign m_err   = sel ? b_err   : a_err;
    assign m_row   = sel ? b_row   : a_row;
    assign m_col   = sel ? b_col   : a_col;
    assign m_k     = sel ? b_k     : a_k;
    assign m_cnt   = sel ? b_cnt   : a_cnt;

    typedef struct packed {
        logic        pass;
        logic [15:0] row;
        logic [15:0] col;
        logic [11:0] k;
        logic        last;
    } cmd_t;

    cmd_t got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_busy"},  m_busy,  0);
        check({tag, "_done"},  m_done,  0);
        check({tag, "_valid"}, m_valid, 0);
        check({tag, "_err"},   m_err,   0);
        check({tag, "_pass"},  m_pass,  0);
        check({tag, "_last"},  m_last,  0);
        check({tag, "_row"},   m_row,   0);
        check({tag, "_col"},   m_col,   0);
        check({tag, "_k"},     m_k,     0);
`ifdef NTT_SCHED_PERF_EN
        check({tag, "_cnt"},   m_cnt,   0);
`endif
    endtask

    // Runs one job from a negedge in IDLE. Optional stall of tile (sr,sc) of pass one for sn
    // cycles, a start pulse when accepted tile #ms goes out, and a reset on tile (ar,ac).
    task automatic run_job(input int n1, input int n2, input int lat, input int sr,
                           input int sc, input int sn, input int ms, input int ar,
                           input int ac);
        int   cd = 0, stall_cnt = 0, busy_cycles = 0, cycles = 0, idx = 0;
        bit   done_seen = 0, aborted = 0, prev_tdone = 0;
        cmd_t cmd, held, e;
        int   tiles = 2 * (n1 / 4) * (n2 / 4);
        got_q.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("valid_after_start", m_valid, 1);
        check("busy_after_start", m_busy, 1);
        while (!done_seen && !aborted && cycles < 3000) begin
            if (prev_tdone) check("valid_after_tdone", m_valid | m_done, 1);
            prev_tdone   = 0;
            tile_done_in = 1'b0;
            start        = 1'b0;
            tile_ready   = 1'b1;
            if (m_busy) busy_cycles++;
            if (m_done) begin
                done_seen = 1;
                check("busy_at_done", m_busy, 0);
                check("busy_cycles", busy_cycles, tiles * (lat + 1) + sn);
`ifdef NTT_SCHED_PERF_EN
                check("cycle_cnt", m_cnt, busy_cycles);
`endif
            end else begin
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        tile_done_in = 1'b1;
                        prev_tdone   = 1;
                    end
                end
                if (m_valid) begin
                    cmd = {m_pass, m_row, m_col, m_k, m_last};
                    if (!m_pass && m_row == 16'(ar) && m_col == 16'(ac)) begin
                        srstn   = 1'b0;
                        aborted = 1;
                    end else if (!m_pass && m_row == 16'(sr) && m_col == 16'(sc) &&
                                 stall_cnt < sn) begin
                        tile_ready = 1'b0;
                        if (stall_cnt > 0) check("stall_stable", cmd === held, 1);
                        held = cmd;
                        stall_cnt++;
                    end else begin
                        got_q.push_back(cmd);
                        cd = lat;
                        if (got_q.size() - 1 == ms) start = 1'b1;
                    end
                end
            end
            cycles++;
            @(negedge clk);
        end
        tile_done_in = 1'b0;
        start        = 1'b0;
        if (aborted) begin
            check_reset("abort");
            srstn = 1'b1;
            @(negedge clk);
        end else begin
            check("done_seen", done_seen, 1);
            check("stall_cycles", stall_cnt, sn);
            check("tile_count", got_q.size(), tiles);
            check("done_single", m_done, 0);
            check("busy_after", m_busy, 0);
            check("valid_after", m_valid, 0);
            for (int p = 0; p < 2; p++) begin
                int nr = (p == 0) ? n1 / 4 : n2 / 4;
                int nc = (p == 0) ? n2 / 4 : n1 / 4;
                for (int r = 0; r < nr; r++) begin
                    for (int c = 0; c < nc; c++) begin
                        e.pass = p[0];
                        e.row  = 16'(r);
                        e.col  = 16'(c);
                        e.k    = (p == 0) ? 12'(n1) : 12'(n2);
                        e.last = (r == nr - 1) && (c == nc - 1);
                        if (idx < got_q.size())
                            check($sformatf("seq%0d", idx), got_q[idx] === e, 1);
                        idx++;
                    end
                end
            end
        end
    endtask

    initial begin
        sel          = 1'b0;
        srstn        = 1'b0;
        start        = 1'b0;
        tile_ready   = 1'b0;
        tile_done_in = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        srstn = 1'b1;
        @(negedge clk);

        // Clean 16x16 job, 3-cycle engine.
        run_job(16, 16, 3, -1, -1, 0, -1, -1, -1);
        check("err_clean", m_err, 0);

        // Spurious completion in IDLE.
        tile_done_in = 1'b1;
        @(negedge clk);
        tile_done_in = 1'b0;
        check("err_spurious", m_err, 1);
        check("busy_spurious", m_busy, 0);
        check("valid_spurious", m_valid, 0);

        // Stall tile (1,2) for 5 cycles, start pulse mid-job.
        run_job(16, 16, 3, 1, 2, 5, 5, -1, -1);
        check("err_sticky", m_err, 1);

        // Reset while tile (2,1) of pass one is offered, then a fresh job.
        run_job(16, 16, 3, -1, -1, 0, -1, 2, 1);
        check("abort_tiles", got_q.size(), 9);
        run_job(16, 16, 3, -1, -1, 0, -1, -1, -1);

        // 8x16 instance.
        sel = 1'b1;
        @(negedge clk);
        run_job(8, 16, 1, -1, -1, 0, -1, -1, -1);
        check("err_b", m_err, 0);

        // 1-cycle engine on the 16x16 instance: 64 busy cycles.
        sel = 1'b0;
        @(negedge clk);
        run_job(16, 16, 1, -1, -1, 0, -1, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_tile_scheduler.md
Name: ntt_tile_scheduler

Overview:
- Sequences the two matrix-multiply passes of the 2D NTT (N = N1*N2) over the tiled systolic datapath.
- Walks the tile grid of each pass and issues one tile command at a time to the tile engine over a valid/ready handshake.
- Waits for each tile's completion pulse before issuing the next, then reports overall done.
- Sits between the top-level host/start logic and the systolic wrapper/engine.

Parameters:
- N1, 16, first NTT dimension; multiple of ARRAY_ROWS and of ARRAY_COLUMNS
- N2, 16, second NTT dimension; multiple of ARRAY_ROWS and of ARRAY_COLUMNS
- ARRAY_ROWS, 4, systolic array rows (tile height)
- ARRAY_COLUMNS, 4, systolic array columns (tile width)
- IDX_W, 16, width of the tile row/column index outputs

Ports:
- clk  input  1  clock
- srstn  input  1  synchronous active-low reset
- start  input  1  begin a full two-pass job; sampled in IDLE only
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse when the last pass-two tile completes
- tile_valid  output  1  tile command valid
- tile_ready  input  1  engine accepts the command when valid&ready
- tile_pass  output  1  0 = pass one (W x X), 1 = pass two (W2 x X2)
- tile_row  output  IDX_W  tile row index
- tile_col  output  IDX_W  tile column index
- tile_k  output  12  inner dimension: N1 in pass one, N2 in pass two
- tile_last  output  1  high with the final tile of the current pass
- tile_done  input  1  engine one-cycle pulse: issued tile finished and written back
- err  output  1  sticky; set on a protocol violation

Behaviour:
- Interface: one clock (clk); reset (srstn) is synchronous and active-low.
- Reset values: state IDLE; busy, done, tile_valid, err, tile_pass, tile_last at 0; tile_row, tile_col, tile_k at 0.
- Pass one grid: rows 0..N1/ARRAY_ROWS-1, columns 0..N2/ARRAY_COLUMNS-1.
- Pass two grid: rows 0..N2/ARRAY_ROWS-1, columns 0..N1/ARRAY_COLUMNS-1.
- Traversal order: row-major, column fastest.
- States:
  - IDLE: start=1 -> ISSUE with pass=0, row=col=0, tile_k=N1, busy=1.
  - ISSUE: tile_valid=1. Command fields are stable while valid and ready are not both high. On valid&ready -> WAIT with tile_valid=0 in the next cycle.
  - WAIT: on tile_done, advance the index (col+1; at the last column, col=0 and row+1).
    - Not the last tile of the pass -> ISSUE.
    - Last tile of pass 0 -> ISSUE with pass=1, row=col=0, tile_k=N2 (pass switch costs no extra cycle).
    - Last tile of pass 1 -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: tile_done in cycle t gives tile_valid=1 in cycle t+1. start in cycle t gives the first tile_valid in cycle t+1.
- Exactly one outstanding tile at a time. tile_ready is ignored outside ISSUE.
- Protocol violations: tile_done outside WAIT, or in the same cycle as the accept handshake, sets err, has no other effect and is not counted. err clears only on reset.
- start while busy is ignored. A start in the same cycle as the done pulse is ignored; a new job needs start in IDLE.
- Reset mid-operation: abandons the job immediately and returns all outputs to their reset values; no done pulse.
- tile_last = (row==last_row)&&(col==last_col) for the current pass, combinational from the registered indices.

Optional Feature:
- Macro: NTT_SCHED_PERF_EN.
- When defined, adds output cycle_cnt [31:0]:
  - cleared on an accepted start;
  - increments every cycle while busy;
  - holds its value after done, until the next start;
  - reset value 0.
- When undefined, the port and counter are absent and behaviour is otherwise identical.

Test Plan:
- Defaults (16/16/4/4), start pulse, tile_ready tied 1, engine returns tile_done 3 cycles after each accept -> 16 pass-0 tiles, then 16 pass-1 tiles, in order (0,0),(0,1)..(3,3); tile_k=16; tile_last on (3,3) of each pass; single done pulse; busy low afterwards.
- N1=8, N2=16 -> pass one uses 2x4 tiles with tile_k=8; pass two uses 4x2 tiles with tile_k=16; done after exactly 16 tile_done pulses.
- tile_ready held 0 for 5 cycles on tile (1,2) -> tile_valid held high and fields stable; accepted on the 6th cycle; no duplicate issue.
- Spurious tile_done in IDLE, and start asserted mid-job -> err=1 in the first case; sequence unchanged in both cases.
- srstn deasserted during tile (2,1) of pass one -> next cycle all outputs at reset values; a new start restarts at pass 0, (0,0).
- With NTT_SCHED_PERF_EN and a 1-cycle engine, cycle_cnt at done equals the total busy cycles (64 for 32 tiles at 2 cycles each), checked against a bench counter.
